rsa_core_arbiter: RTL and testbench
===================================

# rsa_core_arbiter

Shares one `Rsa256Core` modular-exponentiation engine between two independent requesters, such as two Avalon-MM wrapper front ends or a wrapper plus a self-test engine. It grants the core round-robin, captures operands, and issues a single-cycle core start. It returns the result and status to the granted requester only. A busy-cycle watchdog aborts and resets a core that never reports completion.

## Interface
Parameters:
- `BITWIDTH`, 256, operand/result width.
- `TIMEOUT_CYCLES`, 262144, maximum BUSY cycles before abort.

Ports (requester index i ∈ {0,1}):
- `avm_clk` in 1: single clock.
- `avm_rst` in 1: reset, synchronous, active-high.
- `req_i` in 1: request, held high until `gnt_i`.
- `a_i`, `d_i`, `n_i` in BITWIDTH each: operands, stable while `req_i` high.
- `gnt_i` out 1: one-cycle pulse; operands captured this cycle.
- `done_i` out 1: one-cycle pulse; `result_i`/`err_i` valid.
- `result_i` out BITWIDTH: a^d mod n; held until the next grant to i.
- `err_i` out 1: timeout flag; held like `result_i`.
- `core_rst` out 1: reset to the core.
- `core_start` out 1: one-cycle start pulse.
- `core_a`, `core_d`, `core_n` out BITWIDTH each: captured operands, held through BUSY.
- `core_result` in BITWIDTH: core output.
- `core_finished` in 1: core completion flag.

## Operation
- State machine: IDLE → GRANT → START → BUSY → DONE → IDLE.
- IDLE
  - No request: stay in IDLE.
  - Any `req_i` sampled high: select the owner and go to GRANT.
  - Both requests high: pick the requester not served last. The last-served pointer resets so requester 0 wins the first tie.
- GRANT
  - `gnt_owner`=1.
  - `a/d/n_owner` are registered into `core_a/d/n` at the end of the cycle.
  - The owner drops `req` the cycle after `gnt`.
  - A `req` still high when IDLE is next entered counts as a new request.
- START: `core_start`=1 for exactly one cycle; clear the watchdog counter.
- BUSY
  - The counter increments each cycle.
  - On the first cycle `core_finished`=1: register `core_result` into `result_owner`, clear `err_owner`, go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with no finish: `result_owner`=0, `err_owner`=1, pulse `core_rst` for one cycle, go to DONE.
- DONE: `done_owner`=1 for one cycle, then go to IDLE and set last-served to the owner.
- `core_finished` outside BUSY is ignored.
- Requests arriving outside IDLE wait; `req` is never dropped.
- The non-owner's `result`/`err` are never modified.
- Watchdog counter width: $clog2(TIMEOUT_CYCLES+1).

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE; pointer = last served 1, so 0 has priority.
  - `gnt_i`, `done_i`, `core_start`, `err_i` = 0.
  - `result_i` and `core_a/d/n` = 0.
  - `core_rst`=1 while `avm_rst`=1; otherwise high only for the one abort cycle.
- Request latency: `req_i` first sampled high at edge k (IDLE) → `gnt_i` in cycle k+1 → `core_start` in k+2 → BUSY from k+3.
- Completion latency: `core_finished` sampled at edge m → `done_i` and `result_i` in cycle m+1 → IDLE in m+2.
- Total overhead: 4 cycles plus core latency; back-to-back grants are at least 5 cycles apart.
- Timeout: `done_i` with `err_i`=1 follows exactly TIMEOUT_CYCLES BUSY cycles; `core_rst` and `done_i` are in the same cycle.
- Reset mid-operation: return to IDLE next cycle. No `done` for the aborted job; results clear.
- `core_finished` in the same cycle as the timeout threshold: finish wins, `err`=0.

## Structure
- Package `rsa_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GRANT, START, BUSY, DONE);
  - `RSA_BITWIDTH`=256 and `RSA_TIMEOUT_DEFAULT`;
  - the 1-bit owner type `req_id_t`.
- Sub-module `rsa_rr_pick2`: a combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `valid`, `owner`.
- The FSM, operand/result registers and watchdog live in the top module.

## Test plan
- **Single request:** requester 0 with a=2, d=3, n=11, real core → `gnt_0` pulses once; `core_start` one cycle later. `done_0` arrives with `result_0`=8 and `err_0`=0. `gnt_1`, `done_1` and `result_1` stay 0.
- **Simultaneous requests after reset:** a=2, d=3, n=11 on 0 and a=3, d=4, n=7 on 1, both raised the same cycle → requester 0 is served first (result 8), then requester 1 (result 4). The second `gnt` comes 1 cycle after the first `done`'s IDLE return.
- **Fairness:** both requesters hold `req` continuously for 4 jobs → grants alternate 0,1,0,1. No requester is granted twice in a row.
- **Timeout:** stub core never finishes, TIMEOUT_CYCLES=16 → `done_0` with `err_0`=1 and `result_0`=0 exactly 16 BUSY cycles after START. `core_rst` pulses in that same cycle, then IDLE. A new request then completes normally.
- **Reset in BUSY:** `avm_rst` asserted mid-job → next cycle IDLE, all outputs 0, no `done`. `core_finished` arriving afterwards is ignored.
- **Stray finish and late request:** `core_finished` pulsed while IDLE → no `done`. `req_1` raised during BUSY of 0 → held and granted right after `done_0`.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and defaults for the two-requester RSA core arbiter.
// Provides the arbiter state encoding, the owner id type and default sizes.
package rsa_pkg;

    localparam int RSA_BITWIDTH        = 256;
    localparam int RSA_TIMEOUT_DEFAULT = 262144;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        BUSY,
        DONE
    } arb_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/rsa_rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie the requester that was not served last wins.
module rsa_rr_pick2
    import rsa_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic       valid,
    output req_id_t    owner
);

    always_comb begin
        valid = |req;
        if (&req) begin
            owner = ~last;
        end else begin
            owner = req[1];
        end
    end

endmodule

// File: rtl/rsa_core_arbiter.sv
// Shares one modular-exponentiation core between two requesters.
// Provides round-robin grant, operand capture, start pulse, result return and a busy watchdog.
module rsa_core_arbiter
    import rsa_pkg::*;
#(
    parameter int BITWIDTH       = RSA_BITWIDTH,
    parameter int TIMEOUT_CYCLES = RSA_TIMEOUT_DEFAULT
) (
    input  logic                avm_clk,
    input  logic                avm_rst,
    input  logic                req_0,
    input  logic [BITWIDTH-1:0] a_0,
    input  logic [BITWIDTH-1:0] d_0,
    input  logic [BITWIDTH-1:0] n_0,
    output logic                gnt_0,
    output logic                done_0,
    output logic [BITWIDTH-1:0] result_0,
    output logic                err_0,
    input  logic                req_1,
    input  logic [BITWIDTH-1:0] a_1,
    input  logic [BITWIDTH-1:0] d_1,
    input  logic [BITWIDTH-1:0] n_1,
    output logic                gnt_1,
    output logic                done_1,
    output logic [BITWIDTH-1:0] result_1,
    output logic                err_1,
    output logic                core_rst,
    output logic                core_start,
    output logic [BITWIDTH-1:0] core_a,
    output logic [BITWIDTH-1:0] core_d,
    output logic [BITWIDTH-1:0] core_n,
    input  logic [BITWIDTH-1:0] core_result,
    input  logic                core_finished
);

    localparam int              CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   WD_LAST = CW'(TIMEOUT_CYCLES - 1);

    arb_state_t          state_reg, state_next;
    req_id_t             owner_reg, owner_next;
    req_id_t             last_reg, last_next;
    logic [CW-1:0]       wd_reg, wd_next;
    logic [1:0]          gnt_reg, gnt_next;
    logic [1:0]          done_reg, done_next;
    logic                start_reg, start_next;
    logic                core_rst_reg, core_rst_next;
    logic                capture, load_result, load_abort;
    logic [BITWIDTH-1:0] core_a_reg, core_d_reg, core_n_reg;
    logic [BITWIDTH-1:0] a_sel, d_sel, n_sel;
    logic [BITWIDTH-1:0] result_vec [2];
    logic [1:0]          err_vec;
    logic                pick_valid;
    req_id_t             pick_owner;

    rsa_rr_pick2 u_pick (
        .req   ({req_1, req_0}),
        .last  (last_reg),
        .valid (pick_valid),
        .owner (pick_owner)
    );

    assign a_sel = owner_reg ? a_1 : a_0;
    assign d_sel = owner_reg ? d_1 : d_0;
    assign n_sel = owner_reg ? n_1 : n_0;

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        wd_next       = wd_reg;
        gnt_next      = 2'b00;
        done_next     = 2'b00;
        start_next    = 1'b0;
        core_rst_next = 1'b0;
        capture       = 1'b0;
        load_result   = 1'b0;
        load_abort    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next           = pick_owner;
                    gnt_next[pick_owner] = 1'b1;
                    state_next           = GRANT;
                end
            end
            GRANT: begin
                capture    = 1'b1;
                start_next = 1'b1;
                state_next = START;
            end
            START: begin
                wd_next    = '0;
                state_next = BUSY;
            end
            BUSY: begin
                wd_next = wd_reg + CW'(1);
                // A finish on the threshold cycle still counts as a success.
                if (core_finished) begin
                    load_result          = 1'b1;
                    done_next[owner_reg] = 1'b1;
                    state_next           = DONE;
                end else if (wd_reg == WD_LAST) begin
                    load_abort           = 1'b1;
                    core_rst_next        = 1'b1;
                    done_next[owner_reg] = 1'b1;
                    state_next           = DONE;
                end
            end
            DONE: begin
                last_next  = owner_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            last_reg     <= 1'b1;
            wd_reg       <= '0;
            gnt_reg      <= 2'b00;
            done_reg     <= 2'b00;
            start_reg    <= 1'b0;
            core_rst_reg <= 1'b1;
            core_a_reg   <= '0;
            core_d_reg   <= '0;
            core_n_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            wd_reg       <= wd_next;
            gnt_reg      <= gnt_next;
            done_reg     <= done_next;
            start_reg    <= start_next;
            core_rst_reg <= core_rst_next;
            if (capture) begin
                core_a_reg <= a_sel;
                core_d_reg <= d_sel;
                core_n_reg <= n_sel;
            end
        end
    end

    // Each requester's result/err only moves when it owns the finishing job.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_req
        logic [BITWIDTH-1:0] result_reg;
        logic                err_reg;

        always_ff @(posedge avm_clk) begin
            if (avm_rst) begin
                result_reg <= '0;
                err_reg    <= 1'b0;
            end else if (owner_reg == req_id_t'(gi)) begin
                if (load_result) begin
                    result_reg <= core_result;
                    err_reg    <= 1'b0;
                end else if (load_abort) begin
                    result_reg <= '0;
                    err_reg    <= 1'b1;
                end
            end
        end

        assign result_vec[gi] = result_reg;
        assign err_vec[gi]    = err_reg;
    end

    assign gnt_0      = gnt_reg[0];
    assign gnt_1      = gnt_reg[1];
    assign done_0     = done_reg[0];
    assign done_1     = done_reg[1];
    assign result_0   = result_vec[0];
    assign result_1   = result_vec[1];
    assign err_0      = err_vec[0];
    assign err_1      = err_vec[1];
    assign core_rst   = core_rst_reg;
    assign core_start = start_reg;
    assign core_a     = core_a_reg;
    assign core_d     = core_d_reg;
    assign core_n     = core_n_reg;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Self-checking bench: schedule-based reference model, stub core, directed and random requests.
module tb_rsa_core_arbiter;

    localparam int BW = 256;
    localparam int T  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          avm_rst = 1'b1;
    logic [1:0]    req_v = 2'b00;
    logic [BW-1:0] a_v [2];
    logic [BW-1:0] d_v [2];
    logic [BW-1:0] n_v [2];
    logic          gnt_0, gnt_1, done_0, done_1, err_0, err_1;
    logic [BW-1:0] result_0, result_1;
    logic          core_rst, core_start;
    logic [BW-1:0] core_a, core_d, core_n;
    logic [BW-1:0] core_result = '0;
    logic          core_finished = 1'b0;

    rsa_core_arbiter #(.BITWIDTH(BW), .TIMEOUT_CYCLES(T)) dut (
        .avm_clk(clk), .avm_rst(avm_rst),
        .req_0(req_v[0]), .a_0(a_v[0]), .d_0(d_v[0]), .n_0(n_v[0]),
        .gnt_0(gnt_0), .done_0(done_0), .result_0(result_0), .err_0(err_0),
        .req_1(req_v[1]), .a_1(a_v[1]), .d_1(d_v[1]), .n_1(n_v[1]),
        .gnt_1(gnt_1), .done_1(done_1), .result_1(result_1), .err_1(err_1),
        .core_rst(core_rst), .core_start(core_start),
        .core_a(core_a), .core_d(core_d), .core_n(core_n),
        .core_result(core_result), .core_finished(core_finished)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic logic [BW-1:0] modexp(input logic [BW-1:0] a, input logic [BW-1:0] d,
                                            input logic [BW-1:0] n);
        longint unsigned r, b, e, m;
        m = longint'(n[31:0]);
        if (m == 0) return '0;
        r = 1 % m;
        b = longint'(a[31:0]) % m;
        e = longint'(d[31:0]);
        while (e != 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return BW'(r);
    endfunction

    function automatic logic ev(input int sel);
        case (sel)
            0: return gnt_0;
            1: return gnt_1;
            2: return done_0;
            3: return done_1;
            4: return core_start;
            default: return gnt_0 | gnt_1;
        endcase
    endfunction

    // ---------------- requesters ----------------
    int            submitted [2] = '{0, 0};
    int            served    [2] = '{0, 0};
    logic [1:0]    waiting = 2'b00;
    logic [BW-1:0] job_a [2];
    logic [BW-1:0] job_d [2];
    logic [BW-1:0] job_n [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (avm_rst) begin
                req_v[i]   = 1'b0;
                waiting[i] = 1'b0;
                served[i]  = submitted[i];
            end else if (req_v[i] && ev(i)) begin
                req_v[i]   = 1'b0;
                waiting[i] = 1'b1;
            end else if (waiting[i] && ev(2 + i)) begin
                waiting[i] = 1'b0;
                served[i]  = served[i] + 1;
            end else if (!req_v[i] && !waiting[i] && submitted[i] != served[i]) begin
                a_v[i]   = job_a[i];
                d_v[i]   = job_d[i];
                n_v[i]   = job_n[i];
                req_v[i] = 1'b1;
            end
        end
    end

    // ---------------- stub core ----------------
    int            stub_lat  = 5;
    logic          stub_hang = 1'b0;
    logic          stray_en  = 1'b0;
    logic          run = 1'b0;
    int            cnt = 0;
    logic [BW-1:0] res = '0;

    always @(negedge clk) begin
        core_finished = 1'b0;
        if (avm_rst || core_rst) begin
            run = 1'b0;
        end else if (core_start) begin
            run = 1'b1;
            res = modexp(core_a, core_d, core_n);
            if (stub_hang)          cnt = 1000;
            else if (stub_lat != 0) cnt = stub_lat;
            else                    cnt = int'($urandom_range(1, T + 2));
        end else if (run) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                core_finished = 1'b1;
                core_result   = res;
                run           = 1'b0;
            end
        end else if (stray_en && $urandom_range(0, 3) == 0) begin
            core_finished = 1'b1;
            core_result   = BW'($urandom);
        end
    end

    // ---------------- reference model ----------------
    // Expected outputs after each edge, derived from the job timeline:
    // grant at edge g, start after g+1, finish window edges g+3..g+T+2.
    logic          model_valid = 1'b0;
    int            ecount = 0;
    logic          m_active = 1'b0;
    int            m_owner = 0, m_ge = 0, m_idle_from = 0, m_last = 1;
    logic [1:0]    exp_gnt = 2'b00, exp_done = 2'b00, exp_err = 2'b00;
    logic          exp_start = 1'b0, exp_crst = 1'b0;
    logic [BW-1:0] exp_res [2];
    logic [BW-1:0] exp_ca = '0, exp_cd = '0, exp_cn = '0;

    always @(posedge clk) begin
        ecount = ecount + 1;
        if (avm_rst) begin
            model_valid = 1'b1;
            m_active    = 1'b0;
            m_last      = 1;
            m_idle_from = ecount + 1;
            exp_gnt = 2'b00; exp_done = 2'b00; exp_err = 2'b00;
            exp_start = 1'b0; exp_crst = 1'b1;
            exp_res[0] = '0; exp_res[1] = '0;
            exp_ca = '0; exp_cd = '0; exp_cn = '0;
        end else begin
            exp_gnt = 2'b00; exp_done = 2'b00; exp_start = 1'b0; exp_crst = 1'b0;
            if (!m_active) begin
                if (ecount >= m_idle_from && (req_v[0] || req_v[1])) begin
                    if (req_v[0] && req_v[1]) m_owner = 1 - m_last;
                    else                      m_owner = req_v[1] ? 1 : 0;
                    m_active = 1'b1;
                    m_ge     = ecount;
                    exp_gnt[m_owner] = 1'b1;
                end
            end else if (ecount == m_ge + 1) begin
                exp_start = 1'b1;
                exp_ca = a_v[m_owner]; exp_cd = d_v[m_owner]; exp_cn = n_v[m_owner];
            end else if (ecount >= m_ge + 3) begin
                if (core_finished || ecount == m_ge + T + 2) begin
                    if (core_finished) begin
                        exp_res[m_owner] = core_result;
                        exp_err[m_owner] = 1'b0;
                    end else begin
                        exp_res[m_owner] = '0;
                        exp_err[m_owner] = 1'b1;
                        exp_crst = 1'b1;
                    end
                    exp_done[m_owner] = 1'b1;
                    m_active    = 1'b0;
                    m_last      = m_owner;
                    m_idle_from = ecount + 2;
                end
            end
        end
    end

    // ---------------- checking helpers (main process only) ----------------
    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (model_valid) begin
            chk_bit("gnt_0", gnt_0, exp_gnt[0]);
            chk_bit("gnt_1", gnt_1, exp_gnt[1]);
            chk_bit("done_0", done_0, exp_done[0]);
            chk_bit("done_1", done_1, exp_done[1]);
            chk_bit("err_0", err_0, exp_err[0]);
            chk_bit("err_1", err_1, exp_err[1]);
            chk_vec("result_0", result_0, exp_res[0]);
            chk_vec("result_1", result_1, exp_res[1]);
            chk_bit("core_start", core_start, exp_start);
            chk_bit("core_rst", core_rst, exp_crst);
            chk_vec("core_a", core_a, exp_ca);
            chk_vec("core_d", core_d, exp_cd);
            chk_vec("core_n", core_n, exp_cn);
        end
        if (done_0) $display("job done: req0 result=%0h err=%0b cycle=%0d", result_0, err_0, cyc);
        if (done_1) $display("job done: req1 result=%0h err=%0b cycle=%0d", result_1, err_1, cyc);
    endtask

    task automatic wait_ev(input int sel, input int budget, input string name, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (ev(sel)) begin
                at = cyc;
                break;
            end
        end
        n_assert++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL %s: event not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic submit(input int i, input int a, input int d, input int n);
        job_a[i] = BW'(a);
        job_d[i] = BW'(d);
        job_n[i] = BW'(n);
        submitted[i] = submitted[i] + 1;
    endtask

    task automatic do_reset();
        avm_rst = 1'b1;
        tick();
        tick();
        avm_rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int tg, ts, td, tg2, dones, first_owner;
        exp_res[0] = '0; exp_res[1] = '0;
        for (int i = 0; i < 2; i++) begin
            a_v[i] = '0; d_v[i] = '0; n_v[i] = '0;
            job_a[i] = '0; job_d[i] = '0; job_n[i] = '0;
        end

        // Reset values
        tick(); tick(); tick();
        chk_bit("reset_core_rst", core_rst, 1'b1);
        chk_bit("reset_gnt_0", gnt_0, 1'b0);
        chk_vec("reset_result_0", result_0, '0);
        avm_rst = 1'b0;
        repeat (2) tick();

        // Single request: 2^3 mod 11 = 8
        stub_lat = 5;
        submit(0, 2, 3, 11);
        wait_ev(0, 20, "single_gnt0", tg);
        wait_ev(4, 5, "single_start", ts);
        chk_int("start_after_gnt", ts - tg, 1);
        wait_ev(2, 40, "single_done0", td);
        chk_vec("single_result_0", result_0, BW'(8));
        chk_bit("single_err_0", err_0, 1'b0);
        chk_vec("single_result_1", result_1, '0);
        repeat (3) tick();

        // Simultaneous after reset: 0 first (8), then 1 (3^4 mod 7 = 4)
        do_reset();
        submit(0, 2, 3, 11);
        submit(1, 3, 4, 7);
        wait_ev(5, 20, "simul_first_gnt", tg);
        chk_bit("simul_first_is_0", gnt_0, 1'b1);
        wait_ev(2, 40, "simul_done0", td);
        chk_vec("simul_result_0", result_0, BW'(8));
        wait_ev(1, 20, "simul_gnt1", tg2);
        chk_int("simul_gnt1_after_done0", tg2 - td, 2);
        wait_ev(3, 40, "simul_done1", td);
        chk_vec("simul_result_1", result_1, BW'(4));
        repeat (3) tick();

        // Fairness: both keep requesting, grants alternate 0,1,0,1
        submit(0, 5, 7, 23);
        submit(1, 6, 5, 31);
        for (int j = 0; j < 4; j++) begin
            wait_ev(5, 40, "fair_gnt", tg);
            first_owner = gnt_1 ? 1 : 0;
            chk_int("fair_owner", first_owner, j % 2);
            wait_ev(2 + first_owner, 40, "fair_done", td);
            if (j < 2) submit(first_owner, 7 + j, 3 + j, 19);
        end
        repeat (5) tick();

        // Timeout: stub never finishes
        stub_hang = 1'b1;
        submit(0, 5, 6, 13);
        wait_ev(4, 20, "to_start", ts);
        wait_ev(2, 40, "to_done0", td);
        chk_int("to_latency", td - ts, T + 1);
        chk_bit("to_err_0", err_0, 1'b1);
        chk_vec("to_result_0", result_0, '0);
        chk_bit("to_core_rst", core_rst, 1'b1);
        tick();
        chk_bit("to_core_rst_end", core_rst, 1'b0);
        stub_hang = 1'b0;
        submit(0, 2, 3, 11);
        wait_ev(2, 40, "after_to_done0", td);
        chk_bit("after_to_err_0", err_0, 1'b0);
        chk_vec("after_to_result_0", result_0, BW'(8));

        // Finish exactly on the threshold cycle wins
        stub_lat = T;
        submit(1, 3, 4, 7);
        wait_ev(4, 20, "thr_start", ts);
        wait_ev(3, 40, "thr_done1", td);
        chk_int("thr_latency", td - ts, T + 1);
        chk_bit("thr_err_1", err_1, 1'b0);
        chk_vec("thr_result_1", result_1, BW'(4));
        repeat (3) tick();

        // Reset while BUSY, then stray finishes while idle
        stub_lat = 10;
        submit(0, 2, 3, 11);
        wait_ev(4, 20, "rb_start", ts);
        repeat (3) tick();
        avm_rst = 1'b1;
        tick();
        chk_vec("rb_result_0", result_0, '0);
        chk_vec("rb_result_1", result_1, '0);
        chk_vec("rb_core_a", core_a, '0);
        chk_bit("rb_done_0", done_0, 1'b0);
        chk_bit("rb_core_start", core_start, 1'b0);
        tick();
        avm_rst = 1'b0;
        stray_en = 1'b1;
        dones = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (done_0 || done_1) dones++;
        end
        stray_en = 1'b0;
        chk_int("stray_no_done", dones, 0);

        // Late request from 1 during BUSY of 0
        stub_lat = 8;
        submit(0, 4, 5, 9);
        wait_ev(4, 20, "late_start", ts);
        repeat (2) tick();
        submit(1, 3, 4, 7);
        wait_ev(2, 40, "late_done0", td);
        wait_ev(1, 20, "late_gnt1", tg2);
        chk_int("late_gnt1_after_done0", tg2 - td, 2);
        wait_ev(3, 40, "late_done1", td);
        chk_vec("late_result_1", result_1, BW'(4));

        // Random traffic with random latencies, strays and resets
        stub_lat = 0;
        for (int k = 0; k < 1500; k++) begin
            tick();
            stray_en = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (submitted[i] == served[i] && $urandom_range(0, 3) == 0)
                        submit(i, int'($urandom_range(0, 1000)), int'($urandom_range(0, 50)),
                               int'($urandom_range(2, 1000)));
                end
            end
        end
        stray_en = 1'b0;
        repeat (80) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
